// File: rtl/seg_display_scheduler.sv
// Shares the eight-digit seven-segment display among N_REQ requesters: round-robin grant,
// then one clear word and eight write+shift digit loads, then a minimum display hold.
module seg_display_scheduler #(
    parameter int N_REQ           = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int MIN_HOLD_CYCLES = 100_000_000,
    parameter int LZ_BLANK        = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*32-1:0] value,
    input  logic [N_REQ*8-1:0]  blank,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    done,
    output logic                busy,
    output logic                cmd_valid,
    output logic [31:0]         cmd_data,
    input  logic                cmd_ready
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int HW = (MIN_HOLD_CYCLES > 1) ? $clog2(MIN_HOLD_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MIN_HOLD_CYCLES > 0) ? MIN_HOLD_CYCLES - 1 : 0);
    localparam logic [OW-1:0] OWNER_MAX = OW'(N_REQ - 1);
    localparam logic [31:0]   CLEAR_WORD = 32'h0001_0000;
    localparam logic [31:0]   DIGIT_BASE = 32'h0100_0100;
    localparam logic [3:0]    LAST_WORD  = 4'd8;

    typedef enum logic [1:0] {IDLE, CMD, GAP, HOLD} state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   ptr, owner, pick;
    logic            pick_vld;
    logic [31:0]     val_q;
    logic [7:0]      blk_q;
    logic [3:0]      wcnt;
    logic [2:0]      dig_sel;
    logic [GW-1:0]   gap_cnt;
    logic [HW-1:0]   hold_cnt;

    // Off bit covers the explicit mask and, optionally, zero digits above the last non-zero one.
    function automatic logic [31:0] digit_word(input logic [31:0] v, input logic [7:0] b,
                                               input logic [2:0] d);
        logic [31:0] upper;
        logic        off;
        upper = v >> {d, 2'b00};
        off   = b[d] | ((LZ_BLANK != 0) && (d != 3'd0) && (upper == 32'd0));
        return DIGIT_BASE | {27'd0, off, upper[3:0]};
    endfunction

    // First requester at or after ptr, scanning upward with wrap; lowest offset wins.
    always_comb begin
        int j;
        j        = 0;
        pick     = ptr;
        pick_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) begin
                pick     = OW'(j);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_vld) state_nxt = CMD;
            CMD:  if (cmd_ready) state_nxt = GAP;
            GAP: begin
                if (wcnt == LAST_WORD)       state_nxt = (MIN_HOLD_CYCLES == 0) ? IDLE : HOLD;
                else if (gap_cnt == GAP_LAST) state_nxt = CMD;
            end
            HOLD: if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            wcnt     <= '0;
            gap_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (pick_vld) wcnt <= '0;
                CMD:  gap_cnt <= '0;
                GAP: begin
                    if (wcnt == LAST_WORD) begin
                        ptr      <= (owner == OWNER_MAX) ? '0 : owner + 1'b1;
                        hold_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        wcnt    <= wcnt + 4'd1;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                HOLD: hold_cnt <= hold_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // The winner's inputs are captured once; later changes on req/value do not disturb the sequence.
    always_ff @(posedge clk) begin
        if (state == IDLE && pick_vld) begin
            owner <= pick;
            val_q <= value[pick*32 +: 32];
            blk_q <= blank[pick*8 +: 8];
        end
    end

    assign dig_sel = 3'(wcnt - 4'd1);

    always_comb begin
        grant     = '0;
        done      = '0;
        busy      = (state != IDLE);
        cmd_valid = (state == CMD);
        cmd_data  = '0;
        if (state == CMD || state == GAP) grant[owner] = 1'b1;
        if (state == GAP && wcnt == LAST_WORD) done[owner] = 1'b1;
        if (state == CMD) cmd_data = (wcnt == 4'd0) ? CLEAR_WORD : digit_word(val_q, blk_q, dig_sel);
    end
endmodule
